// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Optional checksum support is selected with `IMEM_BOOT_CHECKSUM_EN.
package imem_boot_pkg;

   typedef enum logic [2:0] {
      S_LEN0 = 3'd0,
      S_LEN1 = 3'd1,
      S_DATA = 3'd2,
      S_CHK  = 3'd3,
      S_DONE = 3'd4,
      S_ERR  = 3'd5
   } boot_state_e;

   localparam int LEN_W_DEF      = 16;
   localparam int BYTES_PER_WORD = 4;
   localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

   // Running XOR checksum over payload bytes.
   function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

endpackage

// File: rtl/boot_byte_packer.sv
// Packs an accepted byte stream into little-endian 32-bit words and pulses
// word_valid for one cycle on the cycle after the fourth byte of a word.
module boot_byte_packer
   import imem_boot_pkg::*;
(
   input  logic        clk,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        last_lane,
   output logic [31:0] word,
   output logic        word_valid
);

   logic [1:0]  lane_r;
   logic [23:0] shift_r;
   logic [31:0] word_r;
   logic        word_valid_r;

   assign last_lane  = (lane_r == LAST_LANE);
   assign word       = word_r;
   assign word_valid = word_valid_r;

   // Lane counter, partial-word shift register and completed-word register.
   always_ff @(posedge clk) begin
      if (clear) begin
         lane_r       <= 2'd0;
         shift_r      <= 24'd0;
         word_r       <= 32'd0;
         word_valid_r <= 1'b0;
      end else begin
         word_valid_r <= byte_valid && (lane_r == LAST_LANE);
         if (byte_valid) begin
            lane_r <= lane_r + 2'd1;
            // byte0 ends up in bits [7:0]
            if (lane_r == LAST_LANE) begin
               word_r <= {byte_data, shift_r};
            end else begin
               shift_r <= {byte_data, shift_r[23:8]};
            end
         end
      end
   end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot sequencer: loads a length-prefixed byte image into instruction memory and
// holds the core in reset until the load completes. Checksum: `IMEM_BOOT_CHECKSUM_EN.
module imem_boot_loader
   import imem_boot_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int LEN_W  = LEN_W_DEF
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_rst_n,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam logic [LEN_W:0] CAP = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;
`ifdef IMEM_BOOT_CHECKSUM_EN
   localparam boot_state_e END_STATE = S_CHK;
`else
   localparam boot_state_e END_STATE = S_DONE;
`endif

   boot_state_e       state_r, state_nx_s;
   logic [7:0]        len_lo_r;
   logic [LEN_W-1:0]  len_r;
   logic [LEN_W-1:0]  len_hdr_s;
   logic [LEN_W-1:0]  words_in_r;
   logic [ADDR_W-1:0] addr_r;
   logic              rx_ready_s;
   logic              accept_s;
   logic              pay_acc_s;
   logic              last_lane_s;
   logic              word_valid_s;
   logic [31:0]       word_s;
   logic              busy_s, done_s, error_s;
`ifdef IMEM_BOOT_CHECKSUM_EN
   logic [7:0]        chk_r;
`endif

   assign rx_ready   = rx_ready_s & ~rst;
   assign accept_s   = rx_valid & rx_ready;
   assign pay_acc_s  = accept_s && (state_r == S_DATA);
   assign len_hdr_s  = LEN_W'({rx_data, len_lo_r});
   assign imem_we    = word_valid_s;
   assign imem_wdata = word_s;
   assign imem_addr  = addr_r;
   assign busy       = busy_s;
   assign done       = done_s;
   assign error      = error_s;
   assign core_rst_n = done_s;

   boot_byte_packer u_packer (
      .clk        (clk),
      .clear      (rst),
      .byte_valid (pay_acc_s),
      .byte_data  (rx_data),
      .last_lane  (last_lane_s),
      .word       (word_s),
      .word_valid (word_valid_s)
   );

   // Ready decode; in S_DATA stop taking bytes once every word has been received.
   always_comb begin
      rx_ready_s = 1'b0;
      case (state_r)
         S_LEN0:  rx_ready_s = 1'b1;
         S_LEN1:  rx_ready_s = 1'b1;
         S_DATA:  rx_ready_s = (words_in_r != len_r);
`ifdef IMEM_BOOT_CHECKSUM_EN
         S_CHK:   rx_ready_s = 1'b1;
`endif
         default: rx_ready_s = 1'b0;
      endcase
   end

   // Next-state and status decode.
   always_comb begin
      state_nx_s = state_r;
      busy_s     = 1'b0;
      done_s     = 1'b0;
      error_s    = 1'b0;
      case (state_r)
         S_LEN0: begin
            if (accept_s) begin
               state_nx_s = S_LEN1;
            end else begin
               state_nx_s = S_LEN0;
            end
         end
         S_LEN1: begin
            busy_s = 1'b1;
            if (!accept_s) begin
               state_nx_s = S_LEN1;
            end else if (len_hdr_s == {LEN_W{1'b0}}) begin
               state_nx_s = END_STATE;
            end else if ({1'b0, len_hdr_s} > CAP) begin
               state_nx_s = S_ERR;
            end else begin
               state_nx_s = S_DATA;
            end
         end
         S_DATA: begin
            busy_s = 1'b1;
            // the write of the final word is the one seen once all words are in
            if (word_valid_s && (words_in_r == len_r)) begin
               state_nx_s = END_STATE;
            end else begin
               state_nx_s = S_DATA;
            end
         end
`ifdef IMEM_BOOT_CHECKSUM_EN
         S_CHK: begin
            busy_s = 1'b1;
            if (!accept_s) begin
               state_nx_s = S_CHK;
            end else if (rx_data == chk_r) begin
               state_nx_s = S_DONE;
            end else begin
               state_nx_s = S_ERR;
            end
         end
`endif
         S_DONE: begin
            done_s     = 1'b1;
            state_nx_s = S_DONE;
         end
         S_ERR: begin
            error_s    = 1'b1;
            state_nx_s = S_ERR;
         end
         default: begin
            state_nx_s = S_ERR;
         end
      endcase
   end

   // State, header and word-index registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= S_LEN0;
         len_lo_r   <= 8'd0;
         len_r      <= {LEN_W{1'b0}};
         words_in_r <= {LEN_W{1'b0}};
         addr_r     <= {ADDR_W{1'b0}};
      end else begin
         state_r <= state_nx_s;
         if (accept_s && (state_r == S_LEN0)) begin
            len_lo_r <= rx_data;
         end
         if (accept_s && (state_r == S_LEN1)) begin
            len_r <= len_hdr_s;
         end
         // address is latched alongside the word so it never runs past the last index
         if (pay_acc_s && last_lane_s) begin
            words_in_r <= words_in_r + LEN_W'(1);
            addr_r     <= words_in_r[ADDR_W-1:0];
         end
      end
   end

`ifdef IMEM_BOOT_CHECKSUM_EN
   // Running checksum over payload bytes.
   always_ff @(posedge clk) begin
      if (rst) begin
         chk_r <= 8'd0;
      end else if (pay_acc_s) begin
         chk_r <= chk_update(chk_r, rx_data);
      end
   end
`endif

endmodule
